// File: rtl/ddr_port_bram_responder_pkg.sv
// ddr_port_bram_responder_pkg: shared user-port widths, command layout and engine states
package ddr_port_bram_responder_pkg;
    localparam logic CMD_RW_READ = 1'b1;
    localparam logic CMD_RW_WRITE = 1'b0;
    localparam int BL_W = 6;
    localparam int BYTE_ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int CMD_W = 1 + BL_W + BYTE_ADDR_W;
    localparam int WR_W = MASK_W + DATA_W;
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;
    typedef struct packed {
        logic rw;
        logic [BL_W-1:0] bl;
        logic [BYTE_ADDR_W-1:0] addr;
    } cmd_t;
endpackage

// File: rtl/ddr_port_bram_responder_sync_fifo_fwft.sv
// sync_fifo_fwft: first-word fall-through FIFO with registered full/empty flags
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    logic [CW-1:0] count_n;
    assign push_ok = push && !full;
    assign pop_ok = pop && !empty;
    assign count_n = count + CW'(push_ok) - CW'(pop_ok);
    assign dout = mem[rd_ptr];
    // pointers, occupancy and flags registered from the next occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
            count <= count_n;
            full <= count_n == CW'(DEPTH);
            empty <= count_n == '0;
        end
    end
    // storage is not reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ddr_port_bram_responder.sv
// ddr_port_bram_responder: BRAM-backed responder for the MIG-style cmd/wr/rd user port
module ddr_port_bram_responder
    import ddr_port_bram_responder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CMD_DEPTH = 4,
    parameter int DATA_DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_en,
    input  logic                   cmd_rw,
    input  logic [BL_W-1:0]        cmd_bl,
    input  logic [BYTE_ADDR_W-1:0] cmd_byte_addr,
    output logic                   cmd_full,
    input  logic                   wr_en,
    input  logic [MASK_W-1:0]      wr_mask,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_full,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_empty,
    output logic                   busy,
    output logic [2:0]             err_flags
);
    cmd_t cmd_in, cmd_head;
    logic cmd_empty, cmd_pop;
    logic [$clog2(CMD_DEPTH):0] cmd_cnt;
    logic [WR_W-1:0] wr_head;
    logic wr_empty, wr_pop;
    logic [$clog2(DATA_DEPTH):0] wr_cnt, rd_cnt;
    logic [DATA_W-1:0] rd_head, rdata_q;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    state_t state, state_n;
    logic [BL_W-1:0] bl_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BL_W:0] cnt_q;
    logic rd_vld, rd_issue, wr_last, rd_done;
    logic unused_ok;
    assign cmd_in = '{rw: cmd_rw, bl: cmd_bl, addr: cmd_byte_addr};
    assign unused_ok = ^{cmd_cnt, wr_cnt, cmd_head.addr[BYTE_ADDR_W-1:ADDR_W+2], cmd_head.addr[1:0]};
    sync_fifo_fwft #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .reset(reset), .push(cmd_en), .din(cmd_in), .pop(cmd_pop),
        .dout(cmd_head), .full(cmd_full), .empty(cmd_empty), .count(cmd_cnt)
    );
    sync_fifo_fwft #(.WIDTH(WR_W), .DEPTH(DATA_DEPTH)) u_wr_fifo (
        .clk(clk), .reset(reset), .push(wr_en), .din({wr_mask, wr_data}), .pop(wr_pop),
        .dout(wr_head), .full(wr_full), .empty(wr_empty), .count(wr_cnt)
    );
    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_rd_fifo (
        .clk(clk), .reset(reset), .push(rd_vld), .din(rdata_q), .pop(rd_en),
        .dout(rd_head), .full(), .empty(rd_empty), .count(rd_cnt)
    );
    assign rd_data = rd_empty ? '0 : rd_head;
    assign busy = state != ST_IDLE || !cmd_empty;
    // engine state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else state <= state_n;
    end
    // next state and FIFO handshakes; a read issues only when the read FIFO can absorb it
    // together with the word already in flight
    always_comb begin
        cmd_pop = state == ST_IDLE && !cmd_empty;
        wr_pop = state == ST_WRITE && !wr_empty;
        wr_last = cnt_q == {1'b0, bl_q};
        rd_done = cnt_q == {1'b0, bl_q} + 1'b1;
        rd_issue = state == ST_READ && !rd_done && (32'(rd_cnt) + 32'(rd_vld)) < DATA_DEPTH;
        state_n = state;
        case (state)
            ST_IDLE:  state_n = cmd_empty ? ST_IDLE : (cmd_head.rw == CMD_RW_READ ? ST_READ : ST_WRITE);
            ST_WRITE: state_n = wr_pop && wr_last ? ST_IDLE : ST_WRITE;
            ST_READ:  state_n = rd_done ? ST_IDLE : ST_READ;
            default:  state_n = ST_IDLE;
        endcase
    end
    // burst bookkeeping, read-valid pipeline and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bl_q <= '0;
            addr_q <= '0;
            cnt_q <= '0;
            rd_vld <= 1'b0;
            err_flags <= '0;
        end else begin
            rd_vld <= rd_issue;
            err_flags <= err_flags | {rd_en && rd_empty, wr_en && wr_full, cmd_en && cmd_full};
            if (cmd_pop) begin
                bl_q <= cmd_head.bl;
                addr_q <= cmd_head.addr[ADDR_W+1:2];
                cnt_q <= '0;
            end else if (wr_pop || rd_issue) begin
                addr_q <= addr_q + 1'b1;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
    // byte-enabled BRAM write port and registered read port
    always_ff @(posedge clk) begin
        for (int i = 0; i < MASK_W; i++)
            if (wr_pop && !wr_head[DATA_W+i]) mem[addr_q][8*i +: 8] <= wr_head[8*i +: 8];
        if (rd_issue) rdata_q <= mem[addr_q];
    end
endmodule

// File: tb/tb_ddr_port_bram_responder.sv
// tb_ddr_port_bram_responder: directed and randomized checks against a word-array memory model
module tb_ddr_port_bram_responder;
    localparam int AW = 10;
    localparam int NW = 2**AW;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmd_en = 0, cmd_rw = 0, wr_en = 0, rd_en = 0;
    logic [5:0] cmd_bl = '0;
    logic [29:0] cmd_byte_addr = '0;
    logic [3:0] wr_mask = '0;
    logic [31:0] wr_data = '0;
    logic cmd_full, wr_full, rd_empty, busy;
    logic [31:0] rd_data;
    logic [2:0] err_flags;
    int n_cmp = 0, n_err = 0;
    logic [31:0] model [NW];
    logic [31:0] wd [64];
    logic [3:0] wm [64];
    logic [31:0] d;
    logic [29:0] ba;
    int w, bl;

    always #5 clk = ~clk;

    ddr_port_bram_responder dut (
        .clk(clk), .reset(reset), .cmd_en(cmd_en), .cmd_rw(cmd_rw), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .wr_en(wr_en), .wr_mask(wr_mask),
        .wr_data(wr_data), .wr_full(wr_full), .rd_en(rd_en), .rd_data(rd_data),
        .rd_empty(rd_empty), .busy(busy), .err_flags(err_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic rw, input logic [5:0] b, input logic [29:0] a);
        cmd_rw = rw; cmd_bl = b; cmd_byte_addr = a; cmd_en = 1;
        tick();
        cmd_en = 0;
    endtask

    task automatic push_wr(input logic [3:0] m, input logic [31:0] x);
        wr_mask = m; wr_data = x; wr_en = 1;
        tick();
        wr_en = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3000) begin tick(); k++; end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic pop_word(output logic [31:0] x);
        int k = 0;
        while (rd_empty && k < 300) begin tick(); k++; end
        chk("rd_timeout", 32'(rd_empty), 32'd0);
        x = rd_data;
        rd_en = 1;
        tick();
        rd_en = 0;
    endtask

    function automatic void mwrite(input int wi, input logic [3:0] m, input logic [31:0] x);
        for (int b = 0; b < 4; b++) if (!m[b]) model[wi % NW][8*b +: 8] = x[8*b +: 8];
    endfunction

    task automatic do_write(input logic [29:0] a, input int b, input bit data_first);
        if (!data_first) push_cmd(1'b0, 6'(b), a);
        for (int i = 0; i <= b; i++) push_wr(wm[i], wd[i]);
        if (data_first) push_cmd(1'b0, 6'(b), a);
        wait_idle();
        for (int i = 0; i <= b; i++) mwrite(int'(a[AW+1:2]) + i, wm[i], wd[i]);
    endtask

    task automatic do_read(input string tag, input logic [29:0] a, input int b);
        logic [31:0] x;
        push_cmd(1'b1, 6'(b), a);
        for (int i = 0; i <= b; i++) begin
            pop_word(x);
            chk(tag, x, model[(int'(a[AW+1:2]) + i) % NW]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk("rst_rd_empty", 32'(rd_empty), 32'd1);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_cmd_full", 32'(cmd_full), 32'd0);
        chk("rst_wr_full", 32'(wr_full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_flags), 32'd0);
        reset = 0;
        tick();
        // test 1: write then bl=0 read, exact read latency
        wd[0] = 32'hDEADBEEF; wm[0] = 4'h0;
        do_write(30'h10, 0, 1);
        push_cmd(1'b1, 6'd0, 30'h10);
        tick(); tick();
        chk("t1_empty_n3", 32'(rd_empty), 32'd1);
        tick();
        chk("t1_empty_n4", 32'(rd_empty), 32'd0);
        chk("t1_data", rd_data, 32'hDEADBEEF);
        rd_en = 1; tick(); rd_en = 0;
        chk("t1_popped_empty", 32'(rd_empty), 32'd1);
        chk("t1_popped_data", rd_data, 32'd0);
        // test 2: byte masking
        wd[0] = 32'h11223344; wm[0] = 4'h0;
        do_write(30'h20, 0, 1);
        wd[0] = 32'hAABBCCDD; wm[0] = 4'b0101;
        do_write(30'h20, 0, 0);
        push_cmd(1'b1, 6'd0, 30'h20);
        pop_word(d);
        chk("t2_mask", d, 32'hAA22CC44);
        // test 3: burst wraps at top of BRAM; reads use aliased byte addresses
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); wm[i] = 4'h0; end
        do_write(30'((NW - 2) * 4), 3, 1);
        push_cmd(1'b1, 6'd0, 30'((NW - 2) * 4) | 30'h2000_0001);
        pop_word(d); chk("t3_w1022", d, 32'd1);
        push_cmd(1'b1, 6'd0, 30'((NW - 1) * 4));
        pop_word(d); chk("t3_w1023", d, 32'd2);
        push_cmd(1'b1, 6'd0, 30'h0001_0002);
        pop_word(d); chk("t3_w0", d, 32'd3);
        push_cmd(1'b1, 6'd0, 30'h4);
        pop_word(d); chk("t3_w1", d, 32'd4);
        // test 4: command FIFO fills while the engine stalls on an empty write FIFO
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 6'd0, 30'((200 + i) * 4));
        chk("t4_not_full_yet", 32'(cmd_full), 32'd0);
        push_cmd(1'b0, 6'd0, 30'(204 * 4));
        chk("t4_cmd_full", 32'(cmd_full), 32'd1);
        push_cmd(1'b0, 6'd0, 30'(205 * 4));
        chk("t4_err_cmd_ovf", 32'(err_flags), 32'b001);
        chk("t4_busy_stalled", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            wd[i] = $urandom;
            push_wr(4'h0, wd[i]);
        end
        wait_idle();
        for (int i = 0; i < 5; i++) mwrite(200 + i, 4'h0, wd[i]);
        for (int i = 0; i < 5; i++) do_read("t4_read", 30'((200 + i) * 4), 0);
        // test 5: full-depth burst; read FIFO holds 64 words without overflow
        for (int i = 0; i < 64; i++) begin wd[i] = $urandom; wm[i] = 4'h0; end
        ba = 30'($urandom_range(300, 900) * 4);
        for (int i = 0; i < 64; i++) push_wr(wm[i], wd[i]);
        chk("t5_wr_full", 32'(wr_full), 32'd1);
        push_cmd(1'b0, 6'd63, ba);
        wait_idle();
        for (int i = 0; i < 64; i++) mwrite(int'(ba[AW+1:2]) + i, wm[i], wd[i]);
        push_cmd(1'b1, 6'd63, ba);
        for (int i = 0; i < 150; i++) tick();
        chk("t5_busy_done", 32'(busy), 32'd0);
        chk("t5_no_ovf", 32'(err_flags), 32'b001);
        for (int i = 0; i < 64; i++) begin
            pop_word(d);
            chk("t5_burst", d, model[(int'(ba[AW+1:2]) + i) % NW]);
        end
        chk("t5_drained", 32'(rd_empty), 32'd1);
        rd_en = 1; tick(); rd_en = 0;
        chk("t5_err_underflow", 32'(err_flags), 32'b101);
        // randomized bursts, away from the word used by the reset test
        for (int it = 0; it < 16; it++) begin
            w = $urandom_range(64, 1000);
            bl = $urandom_range(0, 7);
            ba = 30'($urandom);
            ba[AW+1:2] = AW'(w);
            for (int i = 0; i <= bl; i++) begin
                wd[i] = $urandom;
                wm[i] = (^model[(w + i) % NW] === 1'bx) ? 4'h0 : 4'($urandom);
            end
            do_write(ba, bl, 1'($urandom));
            do_read("rand_read", ba, $urandom_range(0, bl));
        end
        // test 6: asynchronous reset in the middle of a read burst
        push_cmd(1'b1, 6'd15, 30'(200 * 4));
        tick(); tick(); tick();
        #2 reset = 1;
        #1;
        chk("t6_rd_empty", 32'(rd_empty), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_err", 32'(err_flags), 32'd0);
        chk("t6_rd_data", rd_data, 32'd0);
        tick();
        reset = 0;
        tick();
        push_cmd(1'b1, 6'd0, 30'h10);
        pop_word(d);
        chk("t6_bram_kept", d, 32'hDEADBEEF);
        chk("t6_final_empty", 32'(rd_empty), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
